div3_sched: RTL
===============

DIV3_SCHED -- requirements
Module: div3_sched

Interface
REQ-001 Parameter: N_REQ, default 4, number of requesters sharing the divider (2..8).
REQ-002 Port: clk  input  1  sole clock; all state on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: req_valid  input  N_REQ  per-requester operand valid.
REQ-005 Port: req_a  input  N_REQ x 16  per-requester dividend, unsigned.
REQ-006 Port: req_ready  output  N_REQ  per-requester accept; at most one bit high.
REQ-007 Port: rsp_valid  output  1  result valid.
REQ-008 Port: rsp_ready  input  1  consumer accept.
REQ-009 Port: rsp_id  output  $clog2(N_REQ)  index of requester owning rsp_q.
REQ-010 Port: rsp_q  output  16  floor(a/3).
REQ-011 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-012 FSM states: IDLE, EXEC, RESP; encoding is the shared enum.
REQ-013 IDLE: winner = first set req_valid bit searching from rr_ptr upward, wrapping modulo N_REQ; req_ready[winner] high combinationally, others low.
REQ-014 No req_valid set in IDLE: all req_ready low, stay IDLE.
REQ-015 Accept (req_valid&req_ready) at edge t: operand and id registered, rr_ptr <= winner+1 mod N_REQ, IDLE->EXEC.
REQ-016 EXEC: registered operand drives divider; quotient registered into rsp_q at edge t+1, EXEC->RESP.
REQ-017 RESP: rsp_valid high from edge t+1 (visible in cycle t+2); rsp_q, rsp_id held stable until handshake.
REQ-018 rsp_valid&rsp_ready at an edge: rsp_valid drops, RESP->IDLE; no new accept in that same cycle (minimum 3 cycles per operation).
REQ-019 req_ready all low outside IDLE regardless of req_valid.
REQ-020 req_valid dropping while not granted: no effect; requester not remembered.
REQ-021 Quotient exact for full range 0..65535; quotient of 0, 1, 2 is 0.
REQ-022 rr_ptr wraps N_REQ-1 -> 0; single persistent requester is re-granted every operation.

Reset
REQ-023 rst high: state IDLE, rr_ptr 0, rsp_valid 0, rsp_q 0, rsp_id 0, operand register 0, busy 0, req_ready all 0 while rst high.
REQ-024 rst asserted mid-EXEC or mid-RESP: operation discarded, no rsp_valid produced after release.
REQ-025 First accept after rst release grants lowest valid index.

Configuration
REQ-026 Macro DIV3_SCHED_REM_EN defined: add output rsp_rem (2 bits) = a - 3*rsp_q, registered with rsp_q, reset 0, same stability rules.
REQ-027 Macro undefined: rsp_rem port and its logic absent; all other behaviour identical.

Structure
REQ-028 Package div3_pkg holds DIV3_W = 16, state enum typedef, and remainder width constant.
REQ-029 Exactly one sub-module: the existing div_by_3 combinational divider (ports a, c), instantiated once, fed from the operand register.
REQ-030 Arbitration and FSM reside in div3_sched; no further sub-modules.

Verification
REQ-031 req_valid[0]=1, req_a[0]=21, rsp_ready=1 -> req_ready[0] same cycle; rsp_valid two cycles later, rsp_q=7, rsp_id=0.
REQ-032 All four valid with a={3,8,0,1}, held -> grant order 0,1,2,3; rsp_q 1,2,0,0; then wraps to 0.
REQ-033 rsp_ready low 5 cycles in RESP with a=65535 -> rsp_valid, rsp_q=21845 stable; req_ready all 0; busy=1.
REQ-034 rst pulse during EXEC (a=300) -> all outputs 0 immediately; no response after release; next grant to index 0.
REQ-035 DIV3_SCHED_REM_EN: a=2 -> rsp_q=0, rsp_rem=2; a=65534 -> rsp_q=21844, rsp_rem=2; a=8 -> rsp_rem=2.
REQ-036 Only req_valid[2] set for 3 operations -> granted each time, rr_ptr cycles to 3 after each accept.

Source files
------------

// File: rtl/div3_pkg.sv
// Shared constants and state encoding for the divide-by-3 scheduler.
package div3_pkg;

  localparam int DIV3_W     = 16;
  localparam int DIV3_REM_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/div_by_3.sv
// Combinational unsigned divide-by-3 over the full DIV3_W operand range.
module div_by_3
  import div3_pkg::*;
(
  input  logic [DIV3_W-1:0] a,
  output logic [DIV3_W-1:0] c
);

  logic [31:0] prod;

  // 43691 = (2^17 + 1) / 3, so the reciprocal multiply is exact for every 16-bit a.
  assign prod = 32'(a) * 32'd43691;
  assign c    = DIV3_W'(prod >> 17);

endmodule

// File: rtl/div3_sched.sv
// Round-robin scheduler sharing one divide-by-3 unit among N_REQ requesters.
// Define DIV3_SCHED_REM_EN to add the rsp_rem remainder output.
module div3_sched
  import div3_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DIV3_W-1:0] req_a,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [DIV3_W-1:0]       rsp_q,
`ifdef DIV3_SCHED_REM_EN
  output logic [DIV3_REM_W-1:0]   rsp_rem,
`endif
  output logic                    busy
);

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   winner;
  logic              found;
  logic [DIV3_W-1:0] op_a;
  logic [DIV3_W-1:0] div_q;
  int                idx;

  div_by_3 u_div (
    .a (op_a),
    .c (div_q)
  );

  // First valid requester at or above rr_ptr, wrapping around.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(rr_ptr) + i) % N_REQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && found && !rst)
      req_ready[winner] = 1'b1;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      op_a      <= '0;
      rsp_valid <= 1'b0;
      rsp_q     <= '0;
      rsp_id    <= '0;
`ifdef DIV3_SCHED_REM_EN
      rsp_rem   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            op_a   <= req_a[int'(winner)*DIV3_W +: DIV3_W];
            rsp_id <= winner;
            rr_ptr <= (winner == ID_W'(N_REQ-1)) ? '0 : winner + 1'b1;
            state  <= EXEC;
          end
        end
        EXEC: begin
          rsp_q     <= div_q;
`ifdef DIV3_SCHED_REM_EN
          rsp_rem   <= DIV3_REM_W'(op_a - div_q * 16'd3);
`endif
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          // Returning to IDLE costs a cycle, so no accept coincides with the handshake.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
